noc_axi4_bridge_resp_arb: RTL and testbench
===========================================

// Module: noc_axi4_bridge_resp_arb
// PURPOSE
//  Weighted round-robin arbiter sharing the single response serializer between read completions (AXI R path)
//  and write completions (AXI B path) of the NoC-AXI4 bridge. Registers one winning beat (header + data)
//  and presents it to the serializer input via valid/ready; bounds starvation of either path.
// PARAMETERS
//  RD_BURST  default 4  max consecutive contended grants to read path before priority passes to write (>=1)
//  WR_BURST  default 1  max consecutive contended grants to write path before priority returns to read (>=1)
// PORTS
//  clk         in   1                  clock
//  rst_n       in   1                  reset, asynchronous, active-low
//  rd_header   in   `MSG_HEADER_WIDTH  request header of completed read
//  rd_data     in   `AXI4_DATA_WIDTH   read data
//  rd_val      in   1                  read completion valid
//  rd_rdy      out  1                  read completion accepted this cycle when rd_val & rd_rdy
//  wr_header   in   `MSG_HEADER_WIDTH  request header of completed write
//  wr_val      in   1                  write completion valid
//  wr_rdy      out  1                  write completion accepted when wr_val & wr_rdy
//  ser_header  out  `MSG_HEADER_WIDTH  header to serializer
//  ser_data    out  `AXI4_DATA_WIDTH   data to serializer (all zeros for write beats)
//  ser_val     out  1                  output beat valid
//  ser_rdy     in   1                  serializer ready
// BEHAVIOUR
//  - Reset: ser_val=0, ser_header=0, ser_data=0, prio=PRIO_RD, burst_cnt=0, perf counters=0. Takes effect
//    immediately, mid-beat included; a held beat is dropped, no handshake completes during reset.
//  - Output register: load = ~ser_val | ser_rdy. Grant only when load; winning beat appears on ser_* next cycle
//    (latency 1). Full throughput: one grant/cycle while ser_rdy stays high. ser_* stable while ser_val & ~ser_rdy.
//  - ser_val clears on ser_val & ser_rdy with no new grant in that cycle.
//  - Winner: only one valid -> that source. Both valid -> prio source. rd_rdy = load & ~(wr_val & prio==PRIO_WR);
//    wr_rdy = load & ~(rd_val & prio==PRIO_RD). rdy never depends on the same source's own val.
//  - Prio FSM (2 states, PRIO_RD / PRIO_WR):
//      contended grant to prio source -> burst_cnt+1; when burst_cnt+1 == RD_BURST (PRIO_RD) or WR_BURST (PRIO_WR),
//      switch state and clear burst_cnt.
//      uncontended grant (other source not valid) -> no state/count change.
//      no grant -> hold.
//  - burst_cnt width $clog2(max(RD_BURST,WR_BURST)+1); never wraps (cleared on switch).
//  - No header decode: header passed unmodified; serializer builds response.
// CONFIGURATION
//  NOC_AXI4_BRIDGE_RESP_ARB_PERF_EN defined: adds outputs rd_grant_cnt, wr_grant_cnt, stall_cnt (32 bit each):
//    grants per source, cycles with ser_val & ~ser_rdy; saturate at 32'hFFFF_FFFF; reset to 0.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  - noc_axi4_bridge_pkg: typedef enum logic {PRIO_RD, PRIO_WR} resp_prio_t; localparam RESP_SRC_RD=0,
//    RESP_SRC_WR=1; perf counter width constant.
//  - One sub-module: noc_axi4_bridge_wrr2 (2-input weighted RR picker: prio FSM + burst_cnt, outputs grant
//    one-hot from req[1:0] and advance enable). Output register and perf counters stay in top.
// TESTING
//  1. Reset mid-beat: ser_val=1 held, ser_rdy=0, assert rst_n=0 -> ser_val=0 same cycle, prio=PRIO_RD after release.
//  2. Read only, ser_rdy=1, 8 back-to-back rd beats -> 8 ser beats on consecutive cycles, 1-cycle latency,
//     order and data preserved, prio stays PRIO_RD.
//  3. Both valid continuously, RD_BURST=4, WR_BURST=1, ser_rdy=1 -> grant pattern R,R,R,R,W repeating.
//  4. Backpressure: ser_rdy=0 for 5 cycles with beat held -> ser_* stable, rd_rdy=wr_rdy=0; ser_rdy=1 ->
//     held beat accepted and next grant loaded same cycle.
//  5. Write beat with wr_header=H -> ser_header=H, ser_data=0; wr grant uncontended -> prio unchanged.
//  6. PERF_EN: 10 rd, 3 wr grants, 7 stall cycles -> rd_grant_cnt=10, wr_grant_cnt=3, stall_cnt=7.

Source files
------------

// File: rtl/noc_axi4_bridge_resp_arb_pkg.sv
// Shared types and constants for the NoC-AXI4 bridge response arbiter.
// Header/data widths default here when the bridge-level macros are not already defined.
`ifndef MSG_HEADER_WIDTH
`define MSG_HEADER_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif

package noc_axi4_bridge_pkg;
    typedef enum logic {PRIO_RD, PRIO_WR} resp_prio_t;

    localparam int RESP_SRC_RD = 0;
    localparam int RESP_SRC_WR = 1;
    localparam int PERF_CNT_W  = 32;
    localparam int HDR_W       = `MSG_HEADER_WIDTH;
    localparam int DATA_W      = `AXI4_DATA_WIDTH;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + PERF_CNT_W'(1);
    endfunction
endpackage

// File: rtl/noc_axi4_bridge_resp_arb_if.sv
// Read/write completion inputs and serializer output of the response arbiter.
// Handshake: a beat transfers on a cycle where val & rdy; rdy never depends on that source's own val.
interface noc_axi4_bridge_resp_arb_if;
    import noc_axi4_bridge_pkg::*;

    logic [HDR_W-1:0]  rd_header;
    logic [DATA_W-1:0] rd_data;
    logic              rd_val;
    logic              rd_rdy;
    logic [HDR_W-1:0]  wr_header;
    logic              wr_val;
    logic              wr_rdy;
    logic [HDR_W-1:0]  ser_header;
    logic [DATA_W-1:0] ser_data;
    logic              ser_val;
    logic              ser_rdy;

    modport slave (
        input  rd_header, rd_data, rd_val, wr_header, wr_val, ser_rdy,
        output rd_rdy, wr_rdy, ser_header, ser_data, ser_val
    );
    modport master (
        output rd_header, rd_data, rd_val, wr_header, wr_val, ser_rdy,
        input  rd_rdy, wr_rdy, ser_header, ser_data, ser_val
    );
endinterface

// File: rtl/noc_axi4_bridge_wrr2.sv
// Two-input weighted round-robin picker: priority FSM plus contended-burst counter.
// Only contended grants advance the counter; uncontended grants leave priority untouched.
module noc_axi4_bridge_wrr2
    import noc_axi4_bridge_pkg::*;
#(
    parameter int RD_BURST = 4,
    parameter int WR_BURST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant,
    output resp_prio_t o_prio
);
    localparam int MAX_B = (RD_BURST > WR_BURST) ? RD_BURST : WR_BURST;
    localparam int CNT_W = $clog2(MAX_B + 1);

    resp_prio_t       r_prio, w_prio_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc, w_limit;
    logic             w_contended;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= PRIO_RD;
            r_cnt  <= '0;
        end else begin
            r_prio <= w_prio_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        w_contended = i_req[RESP_SRC_RD] & i_req[RESP_SRC_WR];
        w_cnt_inc   = r_cnt + CNT_W'(1);
        w_limit     = CNT_W'(RD_BURST);
        o_grant     = '0;
        o_grant[RESP_SRC_RD] = i_en & i_req[RESP_SRC_RD] & ~(i_req[RESP_SRC_WR] & (r_prio == PRIO_WR));
        o_grant[RESP_SRC_WR] = i_en & i_req[RESP_SRC_WR] & ~(i_req[RESP_SRC_RD] & (r_prio == PRIO_RD));
        case (r_prio)
            PRIO_RD: w_limit = CNT_W'(RD_BURST);
            PRIO_WR: w_limit = CNT_W'(WR_BURST);
            default: w_limit = CNT_W'(RD_BURST);
        endcase
        // A contended grant always goes to the priority source, so it alone spends the burst budget.
        if (i_en && w_contended) begin
            if (w_cnt_inc == w_limit) begin
                w_prio_nxt = (r_prio == PRIO_RD) ? PRIO_WR : PRIO_RD;
                w_cnt_nxt  = '0;
            end else begin
                w_cnt_nxt  = w_cnt_inc;
            end
        end
    end

    assign o_prio = r_prio;
endmodule

// File: rtl/noc_axi4_bridge_resp_arb.sv
// Shares the response serializer between read (R) and write (B) completions with a registered output beat.
// Optional NOC_AXI4_BRIDGE_RESP_ARB_PERF_EN adds saturating grant and stall counters.
module noc_axi4_bridge_resp_arb
    import noc_axi4_bridge_pkg::*;
#(
    parameter int RD_BURST = 4,
    parameter int WR_BURST = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    noc_axi4_bridge_resp_arb_if.slave   bus,
    output resp_prio_t                  o_dbg_prio
`ifdef NOC_AXI4_BRIDGE_RESP_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]       rd_grant_cnt,
    output logic [PERF_CNT_W-1:0]       wr_grant_cnt,
    output logic [PERF_CNT_W-1:0]       stall_cnt
`endif
);
    logic              r_ser_val;
    logic [HDR_W-1:0]  r_ser_header;
    logic [DATA_W-1:0] r_ser_data;
    logic              w_load;
    logic [1:0]        w_req, w_grant;
    resp_prio_t        w_prio;

    // rst_n gates load so no completion is accepted while reset is asserted.
    assign w_load = rst_n & (~r_ser_val | bus.ser_rdy);
    assign w_req  = {bus.wr_val, bus.rd_val};

    noc_axi4_bridge_wrr2 #(.RD_BURST(RD_BURST), .WR_BURST(WR_BURST)) u_wrr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_req),
        .i_en    (w_load),
        .o_grant (w_grant),
        .o_prio  (w_prio)
    );

    assign bus.rd_rdy = w_load & ~(bus.wr_val & (w_prio == PRIO_WR));
    assign bus.wr_rdy = w_load & ~(bus.rd_val & (w_prio == PRIO_RD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ser_val    <= 1'b0;
            r_ser_header <= '0;
            r_ser_data   <= '0;
        end else if (w_load) begin
            r_ser_val <= |w_grant;
            if (w_grant[RESP_SRC_RD]) begin
                r_ser_header <= bus.rd_header;
                r_ser_data   <= bus.rd_data;
            end else if (w_grant[RESP_SRC_WR]) begin
                r_ser_header <= bus.wr_header;
                r_ser_data   <= '0;
            end
        end
    end

    assign bus.ser_val    = r_ser_val;
    assign bus.ser_header = r_ser_header;
    assign bus.ser_data   = r_ser_data;
    assign o_dbg_prio     = w_prio;

`ifdef NOC_AXI4_BRIDGE_RESP_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] r_rd_grant_cnt, r_wr_grant_cnt, r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_grant_cnt <= '0;
            r_wr_grant_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_grant[RESP_SRC_RD]) r_rd_grant_cnt <= sat_inc(r_rd_grant_cnt);
            if (w_grant[RESP_SRC_WR]) r_wr_grant_cnt <= sat_inc(r_wr_grant_cnt);
            if (r_ser_val && !bus.ser_rdy) r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign rd_grant_cnt = r_rd_grant_cnt;
    assign wr_grant_cnt = r_wr_grant_cnt;
    assign stall_cnt    = r_stall_cnt;
`endif
endmodule

// File: tb/tb_noc_axi4_bridge_resp_arb.sv
// Directed bench for noc_axi4_bridge_resp_arb (RD_BURST=4, WR_BURST=1).
// Inputs change #1 after the rising edge; outputs are checked away from the edge.
module tb_noc_axi4_bridge_resp_arb;
  import noc_axi4_bridge_pkg::*;

  logic clk;
  logic rst_n;
  resp_prio_t dbg_prio;
  int n_assert;
  int n_fail;

  noc_axi4_bridge_resp_arb_if bus();

`ifdef NOC_AXI4_BRIDGE_RESP_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] rd_grant_cnt, wr_grant_cnt, stall_cnt;
`endif

  noc_axi4_bridge_resp_arb #(.RD_BURST(4), .WR_BURST(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_dbg_prio (dbg_prio)
`ifdef NOC_AXI4_BRIDGE_RESP_ARB_PERF_EN
    ,
    .rd_grant_cnt (rd_grant_cnt),
    .wr_grant_cnt (wr_grant_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.rd_header = '0;
    bus.rd_data = '0;
    bus.rd_val = 1'b0;
    bus.wr_header = '0;
    bus.wr_val = 1'b0;
    bus.ser_rdy = 1'b0;
    repeat (2) cyc();
    chk("rst_ser_val", bus.ser_val, 0);
    chk("rst_ser_header", bus.ser_header, 0);
    chk("rst_ser_data", bus.ser_data, 0);
    chk("rst_prio", dbg_prio, PRIO_RD);
    rst_n = 1'b1;
    cyc();

    // read only, back-to-back, one-cycle latency
    bus.ser_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rd_val = 1'b1;
      bus.rd_header = 32'h100 + 32'(i);
      bus.rd_data = 64'hD0 + 64'(i);
      #1;
      chk("t2_rd_rdy", bus.rd_rdy, 1);
      cyc();
      chk("t2_ser_val", bus.ser_val, 1);
      chk("t2_ser_header", bus.ser_header, 64'h100 + 64'(i));
      chk("t2_ser_data", bus.ser_data, 64'hD0 + 64'(i));
    end
    bus.rd_val = 1'b0;
    cyc();
    chk("t2_drain_val", bus.ser_val, 0);
    chk("t2_prio", dbg_prio, PRIO_RD);

    // both valid: R,R,R,R,W repeating
    bus.rd_val = 1'b1;
    bus.rd_header = 32'hAAAA;
    bus.rd_data = 64'h11;
    bus.wr_val = 1'b1;
    bus.wr_header = 32'hBBBB;
    for (int k = 0; k < 10; k++) begin
      logic exp_rd;
      exp_rd = ((k % 5) != 4);
      #1;
      chk("t3_rd_rdy", bus.rd_rdy, exp_rd);
      chk("t3_wr_rdy", bus.wr_rdy, !exp_rd);
      cyc();
      chk("t3_ser_header", bus.ser_header, exp_rd ? 64'hAAAA : 64'hBBBB);
      chk("t3_ser_data", bus.ser_data, exp_rd ? 64'h11 : 64'h0);
    end
    bus.rd_val = 1'b0;
    bus.wr_val = 1'b0;
    cyc();
    chk("t3_drain_val", bus.ser_val, 0);

    // backpressure: held beat stable, then accept and reload in the same cycle
    bus.ser_rdy = 1'b0;
    bus.rd_val = 1'b1;
    bus.rd_header = 32'h300;
    bus.rd_data = 64'h3D;
    #1;
    chk("t4_first_rd_rdy", bus.rd_rdy, 1);
    cyc();
    bus.rd_header = 32'h301;
    bus.rd_data = 64'h3E;
    bus.wr_val = 1'b1;
    bus.wr_header = 32'h4444;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("t4_hold_rd_rdy", bus.rd_rdy, 0);
      chk("t4_hold_wr_rdy", bus.wr_rdy, 0);
      chk("t4_hold_val", bus.ser_val, 1);
      chk("t4_hold_header", bus.ser_header, 64'h300);
      chk("t4_hold_data", bus.ser_data, 64'h3D);
      cyc();
    end
    bus.ser_rdy = 1'b1;
    #1;
    chk("t4_release_rd_rdy", bus.rd_rdy, 1);
    chk("t4_release_wr_rdy", bus.wr_rdy, 0);
    cyc();
    chk("t4_next_header", bus.ser_header, 64'h301);
    chk("t4_next_data", bus.ser_data, 64'h3E);
    bus.rd_val = 1'b0;
    bus.wr_val = 1'b0;
    cyc();
    chk("t4_drain_val", bus.ser_val, 0);

    // uncontended write beat: data zeroed, priority unchanged
    bus.wr_val = 1'b1;
    bus.wr_header = 32'h5555;
    #1;
    chk("t5_wr_rdy", bus.wr_rdy, 1);
    cyc();
    chk("t5_ser_val", bus.ser_val, 1);
    chk("t5_ser_header", bus.ser_header, 64'h5555);
    chk("t5_ser_data", bus.ser_data, 0);
    chk("t5_prio", dbg_prio, PRIO_RD);
    bus.wr_val = 1'b0;
    cyc();
    chk("t5_drain_val", bus.ser_val, 0);

    // one contended read already spent; three more exhaust the read burst
    bus.rd_val = 1'b1;
    bus.wr_val = 1'b1;
    bus.wr_header = 32'h7777;
    for (int i = 0; i < 3; i++) begin
      bus.rd_header = 32'h600 + 32'(i);
      bus.rd_data = 64'h60 + 64'(i);
      #1;
      chk("t6_rd_rdy", bus.rd_rdy, 1);
      chk("t6_prio_before", dbg_prio, PRIO_RD);
      cyc();
      chk("t6_ser_header", bus.ser_header, 64'h600 + 64'(i));
    end
    #1;
    chk("t6_prio_switched", dbg_prio, PRIO_WR);
    chk("t6_wr_rdy", bus.wr_rdy, 1);
    chk("t6_rd_rdy_blocked", bus.rd_rdy, 0);
    bus.rd_val = 1'b0;
    bus.wr_val = 1'b0;
    bus.ser_rdy = 1'b0;
`ifdef NOC_AXI4_BRIDGE_RESP_ARB_PERF_EN
    chk("perf_rd_grants", rd_grant_cnt, 21);
    chk("perf_wr_grants", wr_grant_cnt, 3);
    chk("perf_stalls", stall_cnt, 5);
`endif
    cyc();
    chk("t1_held_val", bus.ser_val, 1);
    chk("t1_held_header", bus.ser_header, 64'h602);
`ifdef NOC_AXI4_BRIDGE_RESP_ARB_PERF_EN
    chk("perf_stalls_after", stall_cnt, 6);
`endif

    // reset mid-beat: outputs clear at once, no acceptance while in reset
    #2;
    rst_n = 1'b0;
    bus.rd_val = 1'b1;
    bus.rd_header = 32'h800;
    bus.rd_data = 64'h88;
    bus.ser_rdy = 1'b1;
    #1;
    chk("t1_rst_val", bus.ser_val, 0);
    chk("t1_rst_header", bus.ser_header, 0);
    chk("t1_rst_data", bus.ser_data, 0);
    chk("t1_rst_prio", dbg_prio, PRIO_RD);
    chk("t1_rst_rd_rdy", bus.rd_rdy, 0);
`ifdef NOC_AXI4_BRIDGE_RESP_ARB_PERF_EN
    chk("perf_rst_rd", rd_grant_cnt, 0);
    chk("perf_rst_stall", stall_cnt, 0);
`endif
    cyc();
    chk("t1_in_rst_val", bus.ser_val, 0);
    rst_n = 1'b1;
    #1;
    chk("t1_post_rd_rdy", bus.rd_rdy, 1);
    cyc();
    chk("t1_post_val", bus.ser_val, 1);
    chk("t1_post_header", bus.ser_header, 64'h800);
    chk("t1_post_prio", dbg_prio, PRIO_RD);
    bus.rd_val = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
